safe_zone_gen: RTL and testbench
================================

# safe_zone_gen

Parametrised level generator and query store for the safe-zone map. On request it fills a grid of `GRID_W x GRID_H` cells with a spatially correlated random pattern, one cell per clock, seeded from an input, with a forced-safe spawn corner. It then answers per-pixel "is this safe" queries from the renderer and the collision logic through a 2-cycle pipelined read port. It sits between the game-control FSM (regenerate/seed/done) and the pixel pipeline.

## Interface
- `SCREEN_WIDTH`, 800: screen width in pixels.
- `SCREEN_HEIGHT`, 600: screen height in pixels.
- `BLOCK_SIZE`, 10: cell edge in pixels. Grid dimensions:
  - `GRID_W` = `SCREEN_WIDTH/BLOCK_SIZE`
  - `GRID_H` = `SCREEN_HEIGHT/BLOCK_SIZE`
  - `N` = `GRID_W*GRID_H`
- `RAND_WIDTH`, 8: number of LFSR low bits compared against the thresholds.
- `P_NONE`, 64: threshold used when no neighbour is safe.
- `P_ONE`, 128: threshold for every neighbour case not covered by `P_NONE`, `P_TWO` or `P_ALL`.
- `P_TWO`, 192: threshold when upper and left are safe but the diagonal is not.
- `P_ALL`, 64: threshold when upper, left and diagonal are all safe.
- `SPAWN_CELLS`, 2: cells with `col<SPAWN_CELLS && row<SPAWN_CELLS` are forced safe.
- Ports, clock and reset first:
  - `clk` in, 1: clock.
  - `arst_n` in, 1: reset, synchronous, active-low.
  - `i_regenerate` in, 1: start (or restart) generation.
  - `i_seed` in, 16: LFSR seed, sampled when `i_regenerate` is high.
  - `o_rdy` out, 1: map valid and queries meaningful.
  - `o_done` out, 1: one-cycle pulse when a generation completes.
  - `i_x` in, `$clog2(SCREEN_WIDTH)`: query pixel x.
  - `i_y` in, `$clog2(SCREEN_HEIGHT)`: query pixel y.
  - `o_is_safe` out, 1: query result.

## Operation
- FSM states: EMPTY (after reset), GEN, READY.
  - EMPTY or READY → GEN on `i_regenerate`.
  - GEN → READY after cell `N-1` is written.
  - GEN → GEN on `i_regenerate`: restart at cell 0, reload the seed, discard partial results.
- Reset values: state EMPTY, `o_rdy=0`, `o_done=0`, `o_is_safe=0`, col/row counters 0, LFSR `16'h0001`. Map contents are undefined.
- Seed load: LFSR loads `i_seed`. A zero seed loads `16'h0001`.
- LFSR: 16-bit Galois, taps mask `16'hB400`. Advances exactly once per generated cell, including forced spawn cells.
- Scan order is raster: col 0..`GRID_W-1`, then row+1. Col wraps to 0 at `GRID_W-1`; row increments on that wrap.
- Neighbours are read from a `GRID_W`-bit previous-row line buffer plus registered left and diagonal bits. The map RAM is never read for neighbours.
  - upper = cell (row-1, col); 0 if row==0.
  - left = cell (row, col-1); 0 if col==0.
  - diag = cell (row-1, col-1); 0 if row==0 or col==0.
- Threshold selection:
  - all three safe → `P_ALL`.
  - upper & left, not diag → `P_TWO`.
  - none safe → `P_NONE`.
  - otherwise → `P_ONE`.
- Cell value:
  - safe = `lfsr[RAND_WIDTH-1:0] < threshold`, unsigned, threshold width `RAND_WIDTH+1`.
  - Spawn cells write 1 and also feed 1 into the neighbour state.
- Map RAM: `N` x 1 bit, single write port (generator), single read port (queries). Address = `row*GRID_W + col`.
- Query, stage 1: cx=`i_x/BLOCK_SIZE`, cy=`i_y/BLOCK_SIZE` (constant divide), out-of-range flag = `i_x>=SCREEN_WIDTH || i_y>=SCREEN_HEIGHT`, compute address.
- Query, stage 2: RAM read. `o_is_safe` = data && !oor && `o_rdy`.
- Queries are accepted every cycle with no stall. When `o_rdy=0`, `o_is_safe` is 0.

## Timing
- `i_regenerate` high in cycle t:
  - GEN from t+1.
  - Cell k written in cycle t+1+k.
  - Last cell written in cycle t+N.
  - `o_rdy=1` and `o_done=1` in cycle t+N+1.
- `o_rdy` drops in cycle t+1 after any `i_regenerate`, including from READY.
- Query latency: `i_x`/`i_y` presented in cycle q → `o_is_safe` valid in cycle q+2. Fully pipelined.
- Reset mid-GEN: state EMPTY on the next cycle. `o_done` is not pulsed.
- `i_regenerate` held high for several cycles: each cycle restarts generation. Completion counts from the last high cycle.

## Structure
- Package `safe_zone_pkg`:
  - state enum `sz_state_e`.
  - LFSR taps constant `SZ_LFSR_TAPS=16'hB400`.
  - function `sz_lfsr_next(logic [15:0])`.
- Sub-module `sz_lfsr16`:
  - ports: clk, arst_n, load, seed, step, value.
  - zero-seed substitution handled inside the sub-module.
- Map RAM is inferred inside `safe_zone_gen`, with no reset on the array.

## Test plan
- Reset, no regenerate, query (0,0) → `o_is_safe=0` and `o_rdy=0` for all cycles.
- Small grid (`SCREEN 40x30`, `BLOCK 10`, N=12), seed `16'hACE1`, regenerate at t → `o_rdy` rises at t+13, `o_done` is a single pulse at t+13, and the map matches a reference model computing the LFSR sequence and threshold rule.
- Same params, spawn check: query pixels (0,0), (19,19), (15,5) → `o_is_safe=1` at 2-cycle latency, for any seed.
- Thresholds forced (`P_NONE=P_ONE=P_TWO=P_ALL=0`) → only spawn cells safe. Forced to 256 → all 12 cells safe.
- Out-of-range query (`i_x=40`, `i_y=0`) on the small grid → `o_is_safe=0`. Back-to-back queries every cycle each return their own result 2 cycles later.
- Regenerate again at cell 5 of GEN with a new seed → no `o_done` from the first run, `o_done` 13 cycles after the second request, map equals a fresh run with the second seed.

Source files
------------

// File: rtl/safe_zone_pkg.sv
// rtl/safe_zone_pkg.sv - shared types, LFSR taps and step function for the safe-zone map
package safe_zone_pkg;

    typedef enum logic [1:0] {
        SZ_EMPTY = 2'd0,
        SZ_GEN   = 2'd1,
        SZ_READY = 2'd2
    } sz_state_e;

    localparam logic [15:0] SZ_LFSR_TAPS = 16'hB400;

    // One right-shifting Galois step: the bit shifted out selects whether the taps are applied
    function automatic logic [15:0] sz_lfsr_next(input logic [15:0] v);
        return v[0] ? ({1'b0, v[15:1]} ^ SZ_LFSR_TAPS) : {1'b0, v[15:1]};
    endfunction

endpackage

// File: rtl/sz_lfsr16.sv
// rtl/sz_lfsr16.sv - 16-bit Galois LFSR with seed load and per-cell step
module sz_lfsr16
    import safe_zone_pkg::*;
(
    input  logic        clk,
    input  logic        arst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] r_state;

    // Load wins over step; an all-zero state would lock up, so a zero seed becomes 1
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state <= 16'h0001;
        end else if (load) begin
            r_state <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else if (step) begin
            r_state <= sz_lfsr_next(r_state);
        end
    end

    assign value = r_state;

endmodule

// File: rtl/safe_zone_gen.sv
// rtl/safe_zone_gen.sv - safe-zone map generator with a 2-cycle pipelined query port
module safe_zone_gen
    import safe_zone_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BLOCK_SIZE    = 10,
    parameter int RAND_WIDTH    = 8,
    parameter int P_NONE        = 64,
    parameter int P_ONE         = 128,
    parameter int P_TWO         = 192,
    parameter int P_ALL         = 64,
    parameter int SPAWN_CELLS   = 2
) (
    input  logic                             clk,
    input  logic                             arst_n,
    input  logic                             i_regenerate,
    input  logic [15:0]                      i_seed,
    output logic                             o_rdy,
    output logic                             o_done,
    input  logic [$clog2(SCREEN_WIDTH)-1:0]  i_x,
    input  logic [$clog2(SCREEN_HEIGHT)-1:0] i_y,
    output logic                             o_is_safe
);

    localparam int GRID_W = SCREEN_WIDTH / BLOCK_SIZE;
    localparam int GRID_H = SCREEN_HEIGHT / BLOCK_SIZE;
    localparam int N      = GRID_W * GRID_H;
    localparam int CW     = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int RW     = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int AW     = (N > 1) ? $clog2(N) : 1;
    localparam int XW     = $clog2(SCREEN_WIDTH);
    localparam int YW     = $clog2(SCREEN_HEIGHT);

    localparam logic [RAND_WIDTH:0] L_P_NONE = (RAND_WIDTH+1)'(P_NONE);
    localparam logic [RAND_WIDTH:0] L_P_ONE  = (RAND_WIDTH+1)'(P_ONE);
    localparam logic [RAND_WIDTH:0] L_P_TWO  = (RAND_WIDTH+1)'(P_TWO);
    localparam logic [RAND_WIDTH:0] L_P_ALL  = (RAND_WIDTH+1)'(P_ALL);
    localparam logic [XW:0]         L_SW     = (XW+1)'(SCREEN_WIDTH);
    localparam logic [YW:0]         L_SH     = (YW+1)'(SCREEN_HEIGHT);

    sz_state_e           r_state, w_next_state;
    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic [GRID_W-1:0]   r_line;
    logic                r_left, r_diag, r_done;
    logic                w_gen, w_last, w_spawn, w_up_raw, w_up, w_left, w_diag, w_cell;
    logic [RAND_WIDTH:0] w_thr;
    logic [15:0]         w_lfsr;
    logic                w_unused_lfsr;
    logic [AW-1:0]       w_waddr;
    logic                r_mem [0:N-1];

    logic [XW-1:0]       w_cx;
    logic [YW-1:0]       w_cy;
    logic                w_oor;
    logic [AW-1:0]       w_qaddr, r_q_addr;
    logic                r_q_oor1, r_q_oor2, r_q_data;

    sz_lfsr16 u_lfsr (
        .clk    (clk),
        .arst_n (arst_n),
        .load   (i_regenerate),
        .seed   (i_seed),
        .step   (w_gen),
        .value  (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr;
    assign w_last  = (r_col == CW'(GRID_W-1)) && (r_row == RW'(GRID_H-1));
    assign w_spawn = (32'(r_col) < 32'(SPAWN_CELLS)) && (32'(r_row) < 32'(SPAWN_CELLS));
    assign w_waddr = AW'(r_row) * AW'(GRID_W) + AW'(r_col);

    // State register
    always_ff @(posedge clk) begin
        if (!arst_n) r_state <= SZ_EMPTY;
        else         r_state <= w_next_state;
    end

    // Next state: a regenerate always (re)starts GEN; the last cell moves to READY
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SZ_EMPTY, SZ_READY: if (i_regenerate) w_next_state = SZ_GEN;
            SZ_GEN:             if (i_regenerate) w_next_state = SZ_GEN;
                                else if (w_last)  w_next_state = SZ_READY;
            default:            w_next_state = SZ_EMPTY;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        o_rdy = 1'b0;
        w_gen = 1'b0;
        case (r_state)
            SZ_GEN:   w_gen = 1'b1;
            SZ_READY: o_rdy = 1'b1;
            default:  ;
        endcase
    end

    // Completion pulse, suppressed when the final cycle is pre-empted by a restart
    always_ff @(posedge clk) begin
        if (!arst_n) r_done <= 1'b0;
        else         r_done <= w_gen && w_last && !i_regenerate;
    end
    assign o_done = r_done;

    // Raster scan counters, cleared on restart and after the last cell
    always_ff @(posedge clk) begin
        if (!arst_n || i_regenerate || (w_gen && w_last)) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_gen) begin
            if (r_col == CW'(GRID_W-1)) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Neighbour bits come from the line buffer; edges of the grid read as unsafe
    assign w_up_raw = r_line[r_col];
    assign w_up     = (r_row != '0) && w_up_raw;
    assign w_left   = (r_col != '0) && r_left;
    assign w_diag   = (r_row != '0) && (r_col != '0) && r_diag;

    // Threshold pick and cell decision; spawn cells are forced safe
    always_comb begin
        if (w_up && w_left && w_diag)        w_thr = L_P_ALL;
        else if (w_up && w_left)             w_thr = L_P_TWO;
        else if (!w_up && !w_left && !w_diag) w_thr = L_P_NONE;
        else                                  w_thr = L_P_ONE;
        w_cell = w_spawn || ({1'b0, w_lfsr[RAND_WIDTH-1:0]} < w_thr);
    end

    // Line buffer keeps the previous row; the old entry at this column becomes the next diagonal
    always_ff @(posedge clk) begin
        if (w_gen) begin
            r_line[r_col] <= w_cell;
            r_left        <= w_cell;
            r_diag        <= w_up_raw;
        end
    end

    // Map RAM write port, driven by the generator only
    always_ff @(posedge clk) begin
        if (w_gen) r_mem[w_waddr] <= w_cell;
    end

    // Query stage 1 address math; out-of-range pixels are parked on address 0
    assign w_cx    = i_x / XW'(BLOCK_SIZE);
    assign w_cy    = i_y / YW'(BLOCK_SIZE);
    assign w_oor   = ({1'b0, i_x} >= L_SW) || ({1'b0, i_y} >= L_SH);
    assign w_qaddr = w_oor ? '0 : (AW'(w_cy) * AW'(GRID_W) + AW'(w_cx));

    // Query pipeline: stage 1 registers the address, stage 2 registers the RAM data
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_q_addr <= '0;
            r_q_oor1 <= 1'b1;
            r_q_oor2 <= 1'b1;
            r_q_data <= 1'b0;
        end else begin
            r_q_addr <= w_qaddr;
            r_q_oor1 <= w_oor;
            r_q_oor2 <= r_q_oor1;
            r_q_data <= r_mem[r_q_addr];
        end
    end

    assign o_is_safe = r_q_data && !r_q_oor2 && o_rdy;

endmodule

// File: tb/tb_safe_zone_gen.sv
// tb/tb_safe_zone_gen.sv - scoreboard bench for safe_zone_gen on a 4x3 grid
module tb_safe_zone_gen;

    localparam int SW = 40, SH = 30, BS = 10, GW = 4, GH = 3, NC = 12;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        i_regenerate;
    logic [15:0] i_seed;
    logic [5:0]  i_x;
    logic [4:0]  i_y;
    logic        rdy_a, done_a, safe_a;
    logic        rdy_z, done_z, safe_z;
    logic        rdy_f, done_f, safe_f;

    int n_checks = 0;
    int n_fail   = 0;
    int qcount   = 0;

    typedef struct {
        bit   valid;
        int   qid;
        logic ea;
        logic ez;
        logic ef;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    safe_zone_gen #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .BLOCK_SIZE(BS)) u_dut_a (
        .clk(clk), .arst_n(arst_n), .i_regenerate(i_regenerate), .i_seed(i_seed),
        .o_rdy(rdy_a), .o_done(done_a), .i_x(i_x), .i_y(i_y), .o_is_safe(safe_a));

    safe_zone_gen #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .BLOCK_SIZE(BS),
                    .P_NONE(0), .P_ONE(0), .P_TWO(0), .P_ALL(0)) u_dut_z (
        .clk(clk), .arst_n(arst_n), .i_regenerate(i_regenerate), .i_seed(i_seed),
        .o_rdy(rdy_z), .o_done(done_z), .i_x(i_x), .i_y(i_y), .o_is_safe(safe_z));

    safe_zone_gen #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .BLOCK_SIZE(BS),
                    .P_NONE(256), .P_ONE(256), .P_TWO(256), .P_ALL(256)) u_dut_f (
        .clk(clk), .arst_n(arst_n), .i_regenerate(i_regenerate), .i_seed(i_seed),
        .o_rdy(rdy_f), .o_done(done_f), .i_x(i_x), .i_y(i_y), .o_is_safe(safe_f));

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Reference map: direct 2-D neighbour lookup, LFSR stepped once per cell
    function automatic logic [11:0] model_map(input logic [15:0] seed);
        logic [15:0] s;
        bit          m [0:GH-1][0:GW-1];
        logic [11:0] res;
        bit          u, l, d;
        int          thr;
        s = (seed == 16'h0) ? 16'h0001 : seed;
        res = '0;
        for (int r = 0; r < GH; r++) begin
            for (int c = 0; c < GW; c++) begin
                if (c < 2 && r < 2) begin
                    m[r][c] = 1'b1;
                end else begin
                    u = (r > 0) ? m[r-1][c] : 1'b0;
                    l = (c > 0) ? m[r][c-1] : 1'b0;
                    d = (r > 0 && c > 0) ? m[r-1][c-1] : 1'b0;
                    if (u && l && d)        thr = 64;
                    else if (u && l)        thr = 192;
                    else if (!u && !l && !d) thr = 64;
                    else                     thr = 128;
                    m[r][c] = (int'(s[7:0]) < thr);
                end
                res[r*GW+c] = m[r][c];
                s = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
            end
        end
        return res;
    endfunction

    // One query per cycle; the entry pushed two cycles earlier is compared now
    task automatic issue(input int x, input int y, input bit v, input logic ea, input logic ez, input logic ef);
        exp_t e;
        @(posedge clk); #1;
        i_x = 6'(x);
        i_y = 5'(y);
        e.valid = v; e.qid = qcount; e.ea = ea; e.ez = ez; e.ef = ef;
        qcount++;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() > 2) begin
            e = sb.pop_front();
            if (e.valid) begin
                chk($sformatf("query%0d_a", e.qid), safe_a, e.ea);
                chk($sformatf("query%0d_z", e.qid), safe_z, e.ez);
                chk($sformatf("query%0d_f", e.qid), safe_f, e.ef);
            end
        end
    endtask

    task automatic flush();
        issue(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.delete();
    endtask

    task automatic regen(input logic [15:0] seed);
        @(posedge clk); #1;
        i_regenerate = 1'b1;
        i_seed       = seed;
        @(posedge clk); #1;
        i_regenerate = 1'b0;
    endtask

    // Called in cycle t+1 after the last regenerate cycle t
    task automatic gen_check(input string tag);
        for (int k = 1; k <= NC + 2; k++) begin
            @(negedge clk);
            chk($sformatf("%s_rdy_t%0d", tag, k), rdy_a, (k > NC));
            chk($sformatf("%s_done_t%0d", tag, k), done_a, (k == NC + 1));
        end
        chk($sformatf("%s_done_z", tag), rdy_z, 1'b1);
        chk($sformatf("%s_done_f", tag), rdy_f, 1'b1);
    endtask

    task automatic check_map(input logic [15:0] seed);
        logic [11:0] m;
        int x, y;
        bit sp;
        m = model_map(seed);
        for (int r = 0; r < GH; r++) begin
            for (int c = 0; c < GW; c++) begin
                x  = c * BS + ((r * 3 + c * 7) % BS);
                y  = r * BS + ((r * 7 + c * 3) % BS);
                sp = (c < 2 && r < 2);
                issue(x, y, 1'b1, m[r*GW+c], sp, 1'b1);
            end
        end
        issue(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        issue(19, 19, 1'b1, 1'b1, 1'b1, 1'b1);
        issue(15, 5, 1'b1, 1'b1, 1'b1, 1'b1);
        issue(39, 29, 1'b1, m[11], 1'b0, 1'b1);
        issue(40, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(0, 30, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(63, 31, 1'b1, 1'b0, 1'b0, 1'b0);
        flush();
    endtask

    initial begin
        arst_n = 1'b0; i_regenerate = 1'b0; i_seed = 16'h0; i_x = '0; i_y = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rdy", rdy_a, 1'b0);
        chk("reset_done", done_a, 1'b0);
        chk("reset_safe", safe_a, 1'b0);
        @(posedge clk); #1;
        arst_n = 1'b1;

        // No regenerate: queries at (0,0) stay unsafe and the map is not ready
        for (int i = 0; i < 4; i++) issue(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        flush();
        chk("idle_rdy", rdy_a, 1'b0);
        chk("idle_done", done_a, 1'b0);

        regen(16'hACE1);
        gen_check("gen_ace1");
        check_map(16'hACE1);

        // Zero seed from READY behaves as seed 1
        regen(16'h0000);
        gen_check("gen_zero");
        check_map(16'h0000);

        // Restart while cell 5 is being written
        regen(16'h1234);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("restart_done_t%0d", k), done_a, 1'b0);
            chk($sformatf("restart_rdy_t%0d", k), rdy_a, 1'b0);
        end
        @(posedge clk); #1;
        i_regenerate = 1'b1;
        i_seed       = 16'h5A5A;
        @(posedge clk); #1;
        i_regenerate = 1'b0;
        gen_check("gen_restart");
        check_map(16'h5A5A);

        // Held regenerate: the last high cycle and its seed win
        @(posedge clk); #1;
        i_regenerate = 1'b1; i_seed = 16'h1111;
        @(posedge clk); #1;
        i_seed = 16'h2222;
        @(posedge clk); #1;
        i_seed = 16'h3333;
        @(posedge clk); #1;
        i_regenerate = 1'b0;
        gen_check("gen_held");
        check_map(16'h3333);

        // Reset during GEN: back to EMPTY with no completion pulse
        regen(16'hBEEF);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        arst_n = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("rst_gen_done_%0d", k), done_a, 1'b0);
            chk($sformatf("rst_gen_rdy_%0d", k), rdy_a, 1'b0);
        end
        issue(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
